// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - serial issue stage: operand read, registered ALU drive, result capture and writeback
// Three-state IDLE/EXEC/DONE sequencer around an external combinational ALU and a small register file.
module alu_issue_ctrl #(
  parameter int WIDTH = 8,
  parameter int NREGS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [1:0]       in_rd,
  input  logic [1:0]       in_rs1,
  input  logic [1:0]       in_rs2,
  input  logic             in_use_imm,
  input  logic [WIDTH-1:0] in_imm,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_opcode,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  input  logic             alu_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_carry,
  output logic [1:0]       out_rd,
  output logic             out_err
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] rf [NREGS];
  logic [1:0]       rd_q;
  logic             legal_q;
  logic             accept;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0001, 4'b0010, 4'b0011,
      4'b0100, 4'b0110, 4'b1000, 4'b1001: op_legal = 1'b1;
      default:                            op_legal = 1'b0;
    endcase
  endfunction

  assign accept = in_ready && in_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = EXEC;
      end
      EXEC: state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operands are read at accept, so rd aliasing rs1/rs2 needs no forwarding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
      rd_q       <= '0;
      legal_q    <= 1'b0;
      out_result <= '0;
      out_zero   <= 1'b0;
      out_carry  <= 1'b0;
      out_rd     <= '0;
      out_err    <= 1'b0;
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else begin
      if (accept) begin
        alu_a      <= rf[in_rs1];
        alu_b      <= in_use_imm ? in_imm : rf[in_rs2];
        alu_opcode <= in_op;
        rd_q       <= in_rd;
        legal_q    <= op_legal(in_op);
      end
      if (state == EXEC) begin
        out_rd <= rd_q;
        if (legal_q) begin
          out_result <= alu_result;
          out_zero   <= alu_zero;
          out_carry  <= alu_carry;
          out_err    <= 1'b0;
          rf[rd_q]   <= alu_result;
        end else begin
          out_result <= '0;
          out_zero   <= 1'b0;
          out_carry  <= 1'b0;
          out_err    <= 1'b1;
        end
      end
    end
  end

endmodule
